bitmap_plotter: RTL and testbench
=================================

BITMAP_PLOTTER -- requirements
Module: bitmap_plotter

Interface
REQ-001 SHALL have parameter COLS, default 35, meaning pixels per bitmap row.
REQ-002 SHALL have parameter MAX_ROWS, default 14, meaning the largest supported row count; bitmap width is COLS*MAX_ROWS.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn, input, 1, meaning reset: synchronous, active-low.
REQ-005 SHALL have port start, input, 1, meaning a draw request, sampled only in IDLE.
REQ-006 SHALL have port bitmap, input, COLS*MAX_ROWS, meaning the text pixel map; row r, column c is bit COLS*r+c, with column 0 leftmost and row 0 top.
REQ-007 SHALL have port num_rows, input, 4, meaning the number of rows to draw.
REQ-008 SHALL have port x_origin, input, 8, and port y_origin, input, 7, meaning the top-left screen position.
REQ-009 SHALL have ports fg_colour and bg_colour, input, 3 each, meaning the colour for set bits and for clear bits.
REQ-010 SHALL have port draw_bg, input, 1, meaning clear bits are also plotted, in bg_colour.
REQ-011 SHALL have port x, output, 8, and port y, output, 7, meaning the VGA adapter pixel coordinate.
REQ-012 SHALL have port colour, output, 3, and port plot, output, 1, meaning the VGA adapter write data and write strobe.
REQ-013 SHALL have port busy, output, 1, and port done, output, 1, meaning a draw is in progress, and a one-cycle completion pulse.

Function
REQ-014 SHALL implement FSM IDLE -> DRAW -> DONE -> IDLE.
REQ-015 IDLE with start=1 SHALL latch bitmap, num_rows, origins, colours and draw_bg, zero the row and column counters, and enter DRAW.
REQ-016 num_rows > MAX_ROWS SHALL be clamped to MAX_ROWS; num_rows=0 SHALL go directly to DONE with no plot.
REQ-017 DRAW SHALL scan one pixel per cycle, row-major: column 0..COLS-1 within each row, rows 0..N-1 in order.
REQ-018 Pixel k (k = 0..N*COLS-1) SHALL appear on the registered outputs in cycle k+1, where cycle 0 is the cycle start is sampled.
REQ-019 Pixel output: x = x_origin+c and y = y_origin+r, computed at 9 and 8 bits; colour = fg_colour if the bit is set, else bg_colour.
REQ-020 plot SHALL be 1 iff (bit set or draw_bg) and x < 160 and y < 120; off-screen pixels SHALL still consume their cycle but with plot=0.
REQ-021 x and y SHALL output the low 8 and 7 bits of the sums.
REQ-022 After the last pixel the FSM SHALL enter DONE: done=1 for exactly one cycle (cycle N*COLS+1), plot=0, then return to IDLE.
REQ-023 busy SHALL be 1 in DRAW only.
REQ-024 start SHALL be ignored while in DRAW or DONE; latched inputs SHALL not be affected by input changes mid-draw.
REQ-025 start high in DONE SHALL not be sampled; a new draw starts no earlier than the first IDLE cycle.
REQ-026 plot SHALL be 0 whenever not in DRAW.

Reset
REQ-027 resetn=0 at a clock edge SHALL force IDLE and clear the counters and latches; x, y, colour, plot, busy and done SHALL all become 0.
REQ-028 Reset mid-draw SHALL abort the draw with no done pulse; the first start after resetn=1 SHALL be honoured normally.

Verification
REQ-029 Reset: hold resetn=0 for 2 cycles with start=1 -> x=0, y=0, colour=0, plot=0, busy=0, done=0; no draw begins.
REQ-030 SCORE word: 6-row SCORE bitmap (row 0 bits 0-1 = 0, bits 2-4 = 1), x_origin=10, y_origin=5, fg=3'b111, draw_bg=0 -> cycles 1-2 plot=0; cycle 3 plot=1 with x=12, y=5, colour=7; no plot at x=44, y=5; done only in cycle 211.
REQ-031 Background: all-zero bitmap, num_rows=1, draw_bg=1, bg=3'b001, origin (0,0) -> plot=1 in cycles 1-35 with x=0..34, y=0, colour=1; done in cycle 36.
REQ-032 Clipping: all-ones bitmap, num_rows=1, x_origin=150 -> exactly 10 plots (x=150..159); cycles 11-35 plot=0; done in cycle 36.
REQ-033 Ignore and abort: pulse start again in cycle 50 of a 6-row draw -> no restart, done in cycle 211; separately, resetn=0 in cycle 100 -> next cycle busy=0, plot=0, and done never asserted.
REQ-034 Degenerate: num_rows=0 -> done in cycle 1, busy never 1, no plot; num_rows=15 -> behaves as 14 rows, done in cycle 491.

Source files
------------

// File: rtl/bitmap_plotter.sv
// bitmap_plotter: scans a latched text bitmap one pixel per clock and
// emits VGA adapter writes (x, y, colour, plot). Pixels outside the
// 160x120 screen still take their cycle but are not plotted. A draw ends
// with a one-cycle done pulse before the block returns to idle.
module bitmap_plotter #(
    parameter int COLS     = 35,
    parameter int MAX_ROWS = 14
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       start,
    input  logic [COLS*MAX_ROWS-1:0]   bitmap,
    input  logic [3:0]                 num_rows,
    input  logic [7:0]                 x_origin,
    input  logic [6:0]                 y_origin,
    input  logic [2:0]                 fg_colour,
    input  logic [2:0]                 bg_colour,
    input  logic                       draw_bg,
    output logic [7:0]                 x,
    output logic [6:0]                 y,
    output logic [2:0]                 colour,
    output logic                       plot,
    output logic                       busy,
    output logic                       done
);

    localparam int BW = COLS * MAX_ROWS;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = $clog2(MAX_ROWS + 1);
    localparam int IW = (BW > 1) ? $clog2(BW) : 1;

    localparam logic [8:0]    X_LIMIT  = 9'd160;
    localparam logic [7:0]    Y_LIMIT  = 8'd120;
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // State and latched draw parameters
    state_t          state_q,   state_d;
    logic [BW-1:0]   bitmap_q,  bitmap_d;
    logic [RW-1:0]   nrows_q,   nrows_d;
    logic [7:0]      xo_q,      xo_d;
    logic [6:0]      yo_q,      yo_d;
    logic [2:0]      fg_q,      fg_d;
    logic [2:0]      bg_q,      bg_d;
    logic            draw_bg_q, draw_bg_d;

    // Scan position: the pixel that will be emitted at the next edge
    logic [CW-1:0]   col_q,     col_d;
    logic [RW-1:0]   row_q,     row_d;

    // Registered outputs
    logic [7:0]      x_q,       x_d;
    logic [6:0]      y_q,       y_d;
    logic [2:0]      colour_q,  colour_d;
    logic            plot_q,    plot_d;
    logic            busy_q,    busy_d;
    logic            done_q,    done_d;

    // Pixel source: live inputs while idle (pixel 0 goes out on the start
    // edge itself), latched copies while drawing
    logic [BW-1:0]   src_bitmap_s;
    logic [7:0]      src_xo_s;
    logic [6:0]      src_yo_s;
    logic [2:0]      src_fg_s;
    logic [2:0]      src_bg_s;
    logic            src_draw_bg_s;
    logic [CW-1:0]   src_col_s;
    logic [RW-1:0]   src_row_s;

    logic [IW-1:0]   idx_s;
    logic            pix_set_s;
    logic [8:0]      x_sum_s;
    logic [7:0]      y_sum_s;
    logic            on_screen_s;
    logic            pix_plot_s;
    logic [2:0]      pix_colour_s;
    logic [CW-1:0]   col_next_s;
    logic [RW-1:0]   row_next_s;
    logic [RW-1:0]   nrows_clamp_s;
    logic            emit_s;

    // Clamp the requested row count to what the bitmap can hold
    always_comb begin
        if (32'(num_rows) > 32'(MAX_ROWS)) begin
            nrows_clamp_s = RW'(MAX_ROWS);
        end else begin
            nrows_clamp_s = RW'(num_rows);
        end
    end

    // Select where the pixel being emitted this cycle comes from
    always_comb begin
        if (state_q == S_IDLE) begin
            src_bitmap_s  = bitmap;
            src_xo_s      = x_origin;
            src_yo_s      = y_origin;
            src_fg_s      = fg_colour;
            src_bg_s      = bg_colour;
            src_draw_bg_s = draw_bg;
            src_col_s     = '0;
            src_row_s     = '0;
        end else begin
            src_bitmap_s  = bitmap_q;
            src_xo_s      = xo_q;
            src_yo_s      = yo_q;
            src_fg_s      = fg_q;
            src_bg_s      = bg_q;
            src_draw_bg_s = draw_bg_q;
            src_col_s     = col_q;
            src_row_s     = row_q;
        end
    end

    // Pixel value, screen position, visibility and next scan position
    always_comb begin
        idx_s        = IW'(32'(src_row_s) * 32'(COLS) + 32'(src_col_s));
        pix_set_s    = src_bitmap_s[idx_s];
        x_sum_s      = {1'b0, src_xo_s} + 9'(src_col_s);
        y_sum_s      = {1'b0, src_yo_s} + 8'(src_row_s);
        on_screen_s  = (x_sum_s < X_LIMIT) && (y_sum_s < Y_LIMIT);
        pix_plot_s   = (pix_set_s || src_draw_bg_s) && on_screen_s;
        pix_colour_s = pix_set_s ? src_fg_s : src_bg_s;
        if (src_col_s == COL_LAST) begin
            col_next_s = '0;
            row_next_s = src_row_s + RW'(1);
        end else begin
            col_next_s = src_col_s + CW'(1);
            row_next_s = src_row_s;
        end
    end

    // Next-state logic and next values of all registered outputs
    always_comb begin
        state_d   = state_q;
        bitmap_d  = bitmap_q;
        nrows_d   = nrows_q;
        xo_d      = xo_q;
        yo_d      = yo_q;
        fg_d      = fg_q;
        bg_d      = bg_q;
        draw_bg_d = draw_bg_q;
        col_d     = col_q;
        row_d     = row_q;
        x_d       = 8'd0;
        y_d       = 7'd0;
        colour_d  = 3'd0;
        plot_d    = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        emit_s    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bitmap_d  = bitmap;
                    nrows_d   = nrows_clamp_s;
                    xo_d      = x_origin;
                    yo_d      = y_origin;
                    fg_d      = fg_colour;
                    bg_d      = bg_colour;
                    draw_bg_d = draw_bg;
                    col_d     = '0;
                    row_d     = '0;
                    if (nrows_clamp_s == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_DRAW;
                        emit_s  = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRAW: begin
                // Row counter past the last row means every pixel is out
                if (row_q == nrows_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_DRAW;
                    emit_s  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (emit_s) begin
            busy_d   = 1'b1;
            x_d      = x_sum_s[7:0];
            y_d      = y_sum_s[6:0];
            colour_d = pix_colour_s;
            plot_d   = pix_plot_s;
            col_d    = col_next_s;
            row_d    = row_next_s;
        end else begin
            busy_d   = 1'b0;
        end
    end

    // State, latches, counters and outputs with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            bitmap_q  <= '0;
            nrows_q   <= '0;
            xo_q      <= 8'd0;
            yo_q      <= 7'd0;
            fg_q      <= 3'd0;
            bg_q      <= 3'd0;
            draw_bg_q <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            x_q       <= 8'd0;
            y_q       <= 7'd0;
            colour_q  <= 3'd0;
            plot_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitmap_q  <= bitmap_d;
            nrows_q   <= nrows_d;
            xo_q      <= xo_d;
            yo_q      <= yo_d;
            fg_q      <= fg_d;
            bg_q      <= bg_d;
            draw_bg_q <= draw_bg_d;
            col_q     <= col_d;
            row_q     <= row_d;
            x_q       <= x_d;
            y_q       <= y_d;
            colour_q  <= colour_d;
            plot_q    <= plot_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_bitmap_plotter.sv
// Testbench for bitmap_plotter: table of directed draws, hand-written
// reset/ignore/abort sequences and randomized draws, all compared per
// cycle against a behavioural pixel model.
module tb_bitmap_plotter;

    localparam int COLS     = 35;
    localparam int MAX_ROWS = 14;
    localparam int BW       = COLS * MAX_ROWS;
    localparam int LOGN     = 600;

    logic          clk;
    logic          resetn;
    logic          start;
    logic [BW-1:0] bitmap;
    logic [3:0]    num_rows;
    logic [7:0]    x_origin;
    logic [6:0]    y_origin;
    logic [2:0]    fg_colour;
    logic [2:0]    bg_colour;
    logic          draw_bg;
    logic [7:0]    x;
    logic [6:0]    y;
    logic [2:0]    colour;
    logic          plot;
    logic          busy;
    logic          done;

    int checks;
    int errors;

    logic       plot_log [0:LOGN];
    logic [7:0] x_log    [0:LOGN];
    logic [6:0] y_log    [0:LOGN];
    logic [2:0] col_log  [0:LOGN];

    typedef struct {
        logic [BW-1:0] bm;
        logic [3:0]    nr;
        logic [7:0]    xo;
        logic [6:0]    yo;
        logic [2:0]    fg;
        logic [2:0]    bg;
        logic          dbg;
        int            exp_done;
        int            exp_plots;
    } vec_t;

    vec_t vecs [6];

    bitmap_plotter #(.COLS(COLS), .MAX_ROWS(MAX_ROWS)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .bitmap    (bitmap),
        .num_rows  (num_rows),
        .x_origin  (x_origin),
        .y_origin  (y_origin),
        .fg_colour (fg_colour),
        .bg_colour (bg_colour),
        .draw_bg   (draw_bg),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int cyc, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < BW; i++) bitmap[i] = 1'($urandom_range(0, 1));
        num_rows  = 4'($urandom_range(0, 15));
        x_origin  = 8'($urandom_range(0, 255));
        y_origin  = 7'($urandom_range(0, 127));
        fg_colour = 3'($urandom_range(0, 7));
        bg_colour = 3'($urandom_range(0, 7));
        draw_bg   = 1'($urandom_range(0, 1));
    endtask

    task automatic apply_vec(input vec_t v);
        bitmap    = v.bm;
        num_rows  = v.nr;
        x_origin  = v.xo;
        y_origin  = v.yo;
        fg_colour = v.fg;
        bg_colour = v.bg;
        draw_bg   = v.dbg;
    endtask

    function automatic int rows_of(input vec_t v);
        return (int'(v.nr) > MAX_ROWS) ? MAX_ROWS : int'(v.nr);
    endfunction

    // Expected outputs for cycle j of a draw: pixel j-1 during cycles 1..P,
    // done pulse in cycle P+1, idle afterwards
    task automatic model(input vec_t v, input int j, output logic [63:0] expv, output logic eplot);
        int p, k, r, c;
        logic bitv, eb, ed;
        logic [8:0] xs;
        logic [7:0] ys;
        logic [2:0] ec;
        p  = rows_of(v) * COLS;
        eb = (j >= 1 && j <= p);
        ed = (j == p + 1);
        eplot = 1'b0;
        xs = 9'd0;
        ys = 8'd0;
        ec = 3'd0;
        if (eb) begin
            k     = j - 1;
            r     = k / COLS;
            c     = k % COLS;
            bitv  = v.bm[COLS * r + c];
            xs    = 9'(v.xo) + 9'(c);
            ys    = 8'(v.yo) + 8'(r);
            ec    = bitv ? v.fg : v.bg;
            eplot = (bitv || v.dbg) && (xs < 9'd160) && (ys < 8'd120);
        end
        expv = 64'({eb, ed, eplot, eplot ? {xs[7:0], ys[6:0], ec} : 18'd0});
    endtask

    task automatic run_draw(input vec_t v, input bit scramble, input int restart_at,
                            output int done_cyc, output int nplots);
        int lim;
        logic [63:0] expv, actv;
        logic eplot;
        lim      = rows_of(v) * COLS + 3;
        done_cyc = -1;
        nplots   = 0;
        @(negedge clk);
        apply_vec(v);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (scramble) scramble_inputs();
        for (int j = 1; j <= lim; j++) begin
            @(negedge clk);
            model(v, j, expv, eplot);
            actv = 64'({busy, done, plot, eplot ? {x, y, colour} : 18'd0});
            check("pixel", j, actv, expv);
            if (j <= LOGN) begin
                plot_log[j] = plot;
                x_log[j]    = x;
                y_log[j]    = y;
                col_log[j]  = colour;
            end
            if (plot === 1'b1) nplots++;
            if (done === 1'b1 && done_cyc < 0) done_cyc = j;
            if (scramble) scramble_inputs();
            start = (j == restart_at) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
    endtask

    initial begin
        int dc, np, saw_done, saw_plot;
        vec_t v;
        logic [63:0] expv;
        logic eplot;
        logic [BW-1:0] ones;
        checks = 0;
        errors = 0;
        ones   = '1;

        // Reset held two cycles with start high
        resetn = 1'b0;
        start  = 1'b1;
        scramble_inputs();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("reset", i, 64'({x, y, colour, plot, busy, done}), 64'd0);
        end
        resetn = 1'b1;
        start  = 1'b0;
        @(negedge clk);
        check("reset_idle", 0, 64'({busy, done, plot}), 64'd0);

        // Directed table: bitmap, rows, origin, colours, draw_bg, done cycle, plot count
        vecs[0] = '{'0,   4'd1,  8'd0,   7'd0,   3'b110, 3'b001, 1'b1, 36,  35};
        vecs[1] = '{ones, 4'd1,  8'd150, 7'd0,   3'b101, 3'b000, 1'b0, 36,  10};
        vecs[2] = '{ones, 4'd0,  8'd5,   7'd5,   3'b111, 3'b010, 1'b1, 1,   0};
        vecs[3] = '{ones, 4'd15, 8'd0,   7'd0,   3'b011, 3'b000, 1'b0, 491, 490};
        vecs[4] = '{ones, 4'd14, 8'd0,   7'd110, 3'b100, 3'b000, 1'b0, 491, 350};
        vecs[5] = '{ones, 4'd2,  8'd250, 7'd3,   3'b111, 3'b001, 1'b1, 71,  0};
        for (int t = 0; t < 6; t++) begin
            run_draw(vecs[t], 1'b1, -1, dc, np);
            check("table_done", t, 64'(dc), 64'(vecs[t].exp_done));
            check("table_plots", t, 64'(np), 64'(vecs[t].exp_plots));
        end

        // SCORE-like word: row 0 starts 0,0,1,1,1 and column 34 is clear
        for (int i = 0; i < BW; i++) v.bm[i] = 1'($urandom_range(0, 1));
        v.bm[0] = 1'b0; v.bm[1] = 1'b0;
        v.bm[2] = 1'b1; v.bm[3] = 1'b1; v.bm[4] = 1'b1;
        v.bm[34] = 1'b0;
        v.nr = 4'd6; v.xo = 8'd10; v.yo = 7'd5;
        v.fg = 3'b111; v.bg = 3'b010; v.dbg = 1'b0;
        v.exp_done = 211; v.exp_plots = -1;
        run_draw(v, 1'b0, -1, dc, np);
        check("score_c1", 1, 64'(plot_log[1]), 64'd0);
        check("score_c2", 2, 64'(plot_log[2]), 64'd0);
        check("score_c3", 3, 64'({plot_log[3], x_log[3], y_log[3], col_log[3]}),
              64'({1'b1, 8'd12, 7'd5, 3'd7}));
        check("score_x44", 35, 64'(plot_log[35]), 64'd0);
        check("score_done", 0, 64'(dc), 64'd211);

        // Start pulsed in cycle 50 of the same draw is ignored
        run_draw(v, 1'b1, 50, dc, np);
        check("restart_done", 0, 64'(dc), 64'd211);

        // Reset in cycle 100 aborts the draw with no done pulse
        @(negedge clk);
        apply_vec(v);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int j = 1; j <= 100; j++) @(negedge clk);
        model(v, 100, expv, eplot);
        check("abort_pre", 100, 64'({busy, done}), 64'(expv[20:19]));
        resetn = 1'b0;
        @(negedge clk);
        check("abort_post", 101, 64'({busy, plot, done}), 64'd0);
        resetn   = 1'b1;
        saw_done = 0;
        saw_plot = 0;
        for (int j = 0; j < 250; j++) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done++;
            if (plot !== 1'b0) saw_plot++;
        end
        check("abort_quiet", 0, 64'({saw_done[15:0], saw_plot[15:0]}), 64'd0);
        run_draw(vecs[0], 1'b0, -1, dc, np);
        check("after_abort_done", 0, 64'(dc), 64'd36);

        // Randomized draws against the model
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < BW; i++) v.bm[i] = 1'($urandom_range(0, 1));
            v.nr  = 4'($urandom_range(0, 15));
            v.xo  = 8'($urandom_range(0, 255));
            v.yo  = 7'($urandom_range(0, 127));
            v.fg  = 3'($urandom_range(0, 7));
            v.bg  = 3'($urandom_range(0, 7));
            v.dbg = 1'($urandom_range(0, 1));
            v.exp_done  = rows_of(v) * COLS + 1;
            v.exp_plots = -1;
            run_draw(v, 1'b1, (t % 2 == 0) ? 20 : -1, dc, np);
            check("rand_done", t, 64'(dc), 64'(v.exp_done));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
